// File: rtl/spi_seq_pkg.sv
// Shared types and constants for the SPI transaction sequencer.
// Optional command-order checking is enabled by SPI_SEQ_ORDER_CHK_EN.
package spi_seq_pkg;

    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SHIFT_OUT = 3'd1,
        WAIT_RD   = 3'd2,
        SHIFT_IN  = 3'd3,
        GAP       = 3'd4
    } state_e;

    localparam int FRAME_BITS = 11;
    localparam int RD_BITS    = 8;
    localparam int CNT_W      = 4;

    // Wire frame: type MSB repeated as a start marker, then type, then payload.
    function automatic logic [FRAME_BITS-1:0] make_frame(
        input logic [1:0] t,
        input logic [7:0] d
    );
        logic [7:0] payload;
        payload = (t == RD_DATA) ? 8'h00 : d;
        return {t[1], t, payload};
    endfunction

endpackage

// File: rtl/spi_seq_shreg.sv
// Frame shift register (MSB out, serial in at LSB) with a shared
// cycle counter whose done flag fires when the count reaches last.
module spi_seq_shreg
    import spi_seq_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [FRAME_BITS-1:0] frame,
    input  logic                  shift,
    input  logic                  ser_in,
    input  logic                  cnt_clr,
    input  logic                  cnt_en,
    input  logic [CNT_W-1:0]      last,
    output logic                  msb,
    output logic [RD_BITS-1:0]    nxt_byte,
    output logic                  done
);

    logic [FRAME_BITS-1:0] sh;
    logic [CNT_W-1:0]      cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh    <= '0;
            cnt_q <= '0;
        end else begin
            if (load) begin
                sh <= frame;
            end else if (shift) begin
                sh <= {sh[FRAME_BITS-2:0], ser_in};
            end
            if (load || cnt_clr) begin
                cnt_q <= '0;
            end else if (cnt_en) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign msb      = sh[FRAME_BITS-1];
    assign nxt_byte = {sh[RD_BITS-2:0], ser_in};
    assign done     = (cnt_q == last);

endmodule

// File: rtl/spi_txn_sequencer.sv
// SPI master transaction sequencer: one command per frame, MSB first.
// Define SPI_SEQ_ORDER_CHK_EN to add the err output and order checks.
module spi_txn_sequencer
    import spi_seq_pkg::*;
#(
    parameter int RD_WAIT  = 2,
    parameter int IDLE_GAP = 1
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_type,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
`ifdef SPI_SEQ_ORDER_CHK_EN
    output logic       err,
`endif
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    if (RD_WAIT < 1 || RD_WAIT > 15) begin : g_bad_rd_wait
        $fatal(1, "RD_WAIT must be 1..15");
    end
    if (IDLE_GAP < 1 || IDLE_GAP > 15) begin : g_bad_idle_gap
        $fatal(1, "IDLE_GAP must be 1..15");
    end

    state_e state_q, state_n;

    logic                  accept, reject;
    logic                  load, shift, cnt_clr, cnt_en;
    logic                  done, rsp_fire, is_rd_q, ser_in;
    logic [CNT_W-1:0]      last;
    logic [FRAME_BITS-1:0] frame;
    logic [RD_BITS-1:0]    nxt_byte;

`ifdef SPI_SEQ_ORDER_CHK_EN
    logic wr_addr_seen, rd_addr_seen;
`endif

    // cmd_ready is only ever high while the FSM sits in IDLE.
    assign accept = cmd_valid && cmd_ready;
    assign frame  = make_frame(cmd_type, cmd_data);
    assign ser_in = (state_q == SHIFT_IN) ? MISO : 1'b0;

    always_comb begin
`ifdef SPI_SEQ_ORDER_CHK_EN
        reject = (cmd_type == WR_DATA && !wr_addr_seen) ||
                 (cmd_type == RD_DATA && !rd_addr_seen);
`else
        reject = 1'b0;
`endif
    end

    spi_seq_shreg u_shreg (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .frame    (frame),
        .shift    (shift),
        .ser_in   (ser_in),
        .cnt_clr  (cnt_clr),
        .cnt_en   (cnt_en),
        .last     (last),
        .msb      (MOSI),
        .nxt_byte (nxt_byte),
        .done     (done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        load     = 1'b0;
        shift    = 1'b0;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        last     = '0;
        rsp_fire = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_n = reject ? GAP : SHIFT_OUT;
                    load    = !reject;
                end
            end
            SHIFT_OUT: begin
                shift  = 1'b1;
                cnt_en = 1'b1;
                last   = CNT_W'(FRAME_BITS - 1);
                if (done) begin
                    cnt_clr = 1'b1;
                    state_n = is_rd_q ? WAIT_RD : GAP;
                end
            end
            WAIT_RD: begin
                cnt_en = 1'b1;
                last   = CNT_W'(RD_WAIT - 1);
                if (done) begin
                    cnt_clr = 1'b1;
                    state_n = SHIFT_IN;
                end
            end
            SHIFT_IN: begin
                shift  = 1'b1;
                cnt_en = 1'b1;
                last   = CNT_W'(RD_BITS - 1);
                if (done) begin
                    cnt_clr  = 1'b1;
                    rsp_fire = 1'b1;
                    state_n  = GAP;
                end
            end
            GAP: begin
                cnt_en = 1'b1;
                last   = CNT_W'(IDLE_GAP - 1);
                if (done) begin
                    cnt_clr = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs register the upcoming state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            SS_n      <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            is_rd_q   <= 1'b0;
        end else begin
            cmd_ready <= (state_n == IDLE);
            busy      <= (state_n != IDLE);
            SS_n      <= !(state_n == SHIFT_OUT ||
                           state_n == WAIT_RD ||
                           state_n == SHIFT_IN);
            rsp_valid <= rsp_fire;
            if (rsp_fire) begin
                rsp_data <= nxt_byte;
            end
            if (load) begin
                is_rd_q <= (cmd_type == RD_DATA);
            end
        end
    end

`ifdef SPI_SEQ_ORDER_CHK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err          <= 1'b0;
            wr_addr_seen <= 1'b0;
            rd_addr_seen <= 1'b0;
        end else begin
            err <= accept && reject;
            if (accept && cmd_type == WR_ADDR) begin
                wr_addr_seen <= 1'b1;
            end
            if (accept && cmd_type == RD_ADDR) begin
                rd_addr_seen <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_spi_txn_sequencer.sv
// Directed bench for spi_txn_sequencer with a behavioural SPI-slave RAM.
// Also covers the SPI_SEQ_ORDER_CHK_EN build when that macro is defined.
module tb_spi_txn_sequencer;
    import spi_seq_pkg::*;

    localparam int RDW  = 3;
    localparam int GAPC = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_type = 2'b00;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_ready, rsp_valid, busy, SS_n, MOSI;
    logic [7:0] rsp_data;
    logic       MISO = 1'b0;
`ifdef SPI_SEQ_ORDER_CHK_EN
    logic       err;
    int         err_n, err_cyc;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    spi_txn_sequencer #(.RD_WAIT(RDW), .IDLE_GAP(GAPC)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_type  (cmd_type),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy),
`ifdef SPI_SEQ_ORDER_CHK_EN
        .err       (err),
`endif
        .SS_n      (SS_n),
        .MOSI      (MOSI),
        .MISO      (MISO)
    );

    // Slave RAM model: 11-bit frame in, read byte out after RDW wait cycles.
    logic [7:0]  mem [256];
    logic [7:0]  waddr = 8'h00;
    logic [7:0]  raddr = 8'h00;
    logic [10:0] sframe = '0;
    logic        rd_frame = 1'b0;
    int          scnt = 0;

    initial foreach (mem[i]) mem[i] = 8'h00;

    always @(posedge clk) begin
        logic [10:0] f;
        if (SS_n) begin
            scnt     <= 0;
            rd_frame <= 1'b0;
        end else begin
            scnt <= scnt + 1;
            f = {sframe[9:0], MOSI};
            if (scnt < 11) sframe <= f;
            if (scnt == 10) begin
                case (f[9:8])
                    2'b00: waddr <= f[7:0];
                    2'b01: mem[waddr] <= f[7:0];
                    2'b10: raddr <= f[7:0];
                    default: rd_frame <= 1'b1;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        int j;
        logic [7:0] b;
        j = scnt + 1 - (12 + RDW);
        b = mem[raddr];
        if (!SS_n && rd_frame && j >= 0 && j < 8) MISO = b[7 - j];
        else MISO = 1'b0;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_cmd(
        input  logic [1:0]  t,
        input  logic [7:0]  d,
        output logic [10:0] bits,
        output int          low,
        output int          rsp_n,
        output logic [7:0]  rsp_d,
        output int          rsp_cyc,
        output int          rdy_cyc,
        output int          busy_bad
    );
        int k;
        bits = '0; low = 0; rsp_n = 0; rsp_d = 8'h00;
        rsp_cyc = -1; rdy_cyc = -1; busy_bad = 0;
`ifdef SPI_SEQ_ORDER_CHK_EN
        err_n = 0; err_cyc = -1;
`endif
        @(negedge clk);
        cmd_type = t; cmd_data = d; cmd_valid = 1'b1;
        k = 0;
        while (!cmd_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!cmd_ready) begin
            chk("accept_timeout", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            if (!SS_n) begin
                if (low < 11) bits = {bits[9:0], MOSI};
                low++;
            end
            if (rsp_valid) begin
                rsp_n++; rsp_d = rsp_data; rsp_cyc = c;
            end
`ifdef SPI_SEQ_ORDER_CHK_EN
            if (err) begin
                err_n++; err_cyc = c;
            end
`endif
            if (cmd_ready) begin
                rdy_cyc = c;
                break;
            end
            if (!busy) busy_bad++;
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [1:0]  t;
        logic [7:0]  d;
        logic [10:0] exp_bits;
        int          exp_low;
        int          exp_rsp;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [10:0] bits;
        logic [7:0]  rd;
        int low, rn, rc, rdy, bb;
        int acc, frames, hi, gap_bad, ngaps, prev_ss, sbusy_bad, rsp_seen;

        vecs[0] = '{WR_ADDR, 8'h3C, 11'h03C, 11, 0, 8'h00};
        vecs[1] = '{WR_ADDR, 8'h05, 11'h005, 11, 0, 8'h00};
        vecs[2] = '{WR_DATA, 8'hA7, 11'h1A7, 11, 0, 8'h00};
        vecs[3] = '{RD_ADDR, 8'h05, 11'h605, 11, 0, 8'h00};
        vecs[4] = '{RD_DATA, 8'hFF, 11'h700, 22, 1, 8'hA7};
        vecs[5] = '{WR_DATA, 8'h5A, 11'h15A, 11, 0, 8'h00};
        vecs[6] = '{RD_DATA, 8'h00, 11'h700, 22, 1, 8'h5A};
        vecs[7] = '{WR_ADDR, 8'h80, 11'h080, 11, 0, 8'h00};

        repeat (2) @(negedge clk);
        chk("rst_ss_n", 32'(SS_n), 32'd1);
        chk("rst_mosi", 32'(MOSI), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        rst = 1'b0;
        #1 chk("ready_before_edge", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        chk("ready_after_release", 32'(cmd_ready), 32'd1);

`ifdef SPI_SEQ_ORDER_CHK_EN
        run_cmd(RD_DATA, 8'h00, bits, low, rn, rd, rc, rdy, bb);
        chk("rej_err_count", 32'(err_n), 32'd1);
        chk("rej_err_cycle", 32'(err_cyc), 32'd1);
        chk("rej_ss_low", 32'(low), 32'd0);
        chk("rej_ready_cycle", 32'(rdy), 32'(GAPC + 1));
        chk("rej_rsp", 32'(rn), 32'd0);
        run_cmd(RD_ADDR, 8'h00, bits, low, rn, rd, rc, rdy, bb);
        chk("rdaddr_bits", 32'(bits), 32'h600);
        chk("rdaddr_low", 32'(low), 32'd11);
        chk("rdaddr_err", 32'(err_n), 32'd0);
`endif

        for (int i = 0; i < 8; i++) begin
            run_cmd(vecs[i].t, vecs[i].d, bits, low, rn, rd, rc, rdy, bb);
            chk($sformatf("v%0d_bits", i), 32'(bits), 32'(vecs[i].exp_bits));
            chk($sformatf("v%0d_low", i), 32'(low), 32'(vecs[i].exp_low));
            chk($sformatf("v%0d_rsp_n", i), 32'(rn), 32'(vecs[i].exp_rsp));
            chk($sformatf("v%0d_ready_cyc", i), 32'(rdy),
                32'(vecs[i].exp_low + GAPC + 1));
            chk($sformatf("v%0d_busy", i), 32'(bb), 32'd0);
            if (vecs[i].exp_rsp != 0) begin
                chk($sformatf("v%0d_rsp_data", i), 32'(rd), 32'(vecs[i].exp_data));
                chk($sformatf("v%0d_rsp_cyc", i), 32'(rc), 32'(11 + RDW + 8 + 1));
            end
`ifdef SPI_SEQ_ORDER_CHK_EN
            chk($sformatf("v%0d_err", i), 32'(err_n), 32'd0);
`endif
            if (i == 0) chk("slave_waddr", 32'(waddr), 32'h3C);
        end
        chk("rsp_data_hold", 32'(rsp_data), 32'h5A);

        // Reset in the middle of a read frame, at bit 6.
        @(negedge clk);
        cmd_type = RD_DATA; cmd_data = 8'h00; cmd_valid = 1'b1;
        for (int k = 0; k < 50 && !cmd_ready; k++) @(negedge clk);
        chk("mid_accept", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid_ss_low", 32'(SS_n), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_ss_n", 32'(SS_n), 32'd1);
        chk("mid_rst_mosi", 32'(MOSI), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rsp_seen = 0;
        #1 chk("mid_ready_low", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        chk("mid_ready_back", 32'(cmd_ready), 32'd1);
        for (int k = 0; k < 30; k++) begin
            if (rsp_valid) rsp_seen++;
            @(negedge clk);
        end
        chk("mid_no_rsp", 32'(rsp_seen), 32'd0);
        run_cmd(WR_ADDR, 8'h3C, bits, low, rn, rd, rc, rdy, bb);
        chk("post_rst_bits", 32'(bits), 32'h03C);
        chk("post_rst_low", 32'(low), 32'd11);
        chk("post_rst_ready", 32'(rdy), 32'(11 + GAPC + 1));

        // cmd_valid held across three commands.
        @(negedge clk);
        cmd_type = WR_ADDR; cmd_data = 8'h11; cmd_valid = 1'b1;
        acc = 0; frames = 0; hi = 0; gap_bad = 0; ngaps = 0;
        prev_ss = 1; sbusy_bad = 0;
        for (int c = 0; c < 80; c++) begin
            if (cmd_valid && cmd_ready) acc++;
            if (!SS_n && prev_ss == 1) begin
                frames++;
                if (frames > 1) begin
                    ngaps++;
                    if (hi != GAPC + 1) gap_bad++;
                end
                hi = 0;
            end
            if (SS_n) hi++;
            if (!SS_n && !busy) sbusy_bad++;
            prev_ss = int'(SS_n);
            @(negedge clk);
            if (acc == 3) cmd_valid = 1'b0;
        end
        chk("held_accepts", 32'(acc), 32'd3);
        chk("held_frames", 32'(frames), 32'd3);
        chk("held_gaps", 32'(ngaps), 32'd2);
        chk("held_gap_len", 32'(gap_bad), 32'd0);
        chk("held_busy", 32'(sbusy_bad), 32'd0);
        chk("held_slave_waddr", 32'(waddr), 32'h11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
